// File: rtl/idma_obi_arb_pkg.sv
// Shared types for the iDMA OBI write arbiter.
//   - Default OBI request/response structs (a, r channels).
//   - Index / count typedefs sized for the default configuration.
//   - Arbiter FSM state enum.
// Optional feature macro used by the arbiter: IDMA_OBI_WRITE_ARB_PRIO_EN
package idma_obi_arb_pkg;

  localparam int unsigned NumInpDef  = 4;
  localparam int unsigned MaxOutDef  = 4;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned AidWidth   = 1;

  // Index width never drops below one bit so a single-bit index is still legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Enough bits to hold the values 0..m inclusive.
  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  typedef logic [idx_width(NumInpDef)-1:0] idx_t;
  typedef logic [cnt_width(MaxOutDef)-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [AidWidth-1:0]    aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [AidWidth-1:0]  rid;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/idma_obi_write_arb_idx_fifo.sv
// In-order FIFO of requester indices, synchronous active-high reset.
// Ports:
//   clk, rst        clock / synchronous reset
//   push, push_data write one index (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry
//   full, empty     occupancy flags
//   count           number of stored entries
module idma_obi_write_arb_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [Width-1:0] push_data,
  input  logic            pop,
  output logic [Width-1:0] head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CntW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/idma_obi_write_arbiter.sv
// Shares one OBI write manager port between NumInp iDMA write engines.
// The winner's index is pushed into an in-order FIFO on every handshake so
// that (in-order) OBI responses can be routed back to the right engine.
// Ports:
//   clk_i, rst_i  clock / synchronous active-high reset
//   inp_req_i     engine requests (NumInp)
//   inp_rsp_o     engine responses (NumInp); r is broadcast
//   mgr_req_o     shared manager request
//   mgr_rsp_i     shared manager response
//   busy_o        outstanding entries or any engine requesting
//   err_o         sticky: rvalid seen with nothing outstanding
// Config macro: IDMA_OBI_WRITE_ARB_PRIO_EN selects fixed lowest-index
// priority instead of round-robin.
module idma_obi_write_arbiter
  import idma_obi_arb_pkg::*;
#(
  parameter int unsigned NumInp         = NumInpDef,
  parameter int unsigned MaxOutstanding = MaxOutDef,
  parameter type         write_req_t    = obi_req_t,
  parameter type         write_rsp_t    = obi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  write_req_t inp_req_i [NumInp],
  output write_rsp_t inp_rsp_o [NumInp],
  output write_req_t mgr_req_o,
  input  write_rsp_t mgr_rsp_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned IdxW = idx_width(NumInp);
  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] hold_q, hold_d;
  logic [IdxW-1:0] cand, sel;
  logic            any_req, forward, push;
  logic [IdxW-1:0] head;
  logic            fifo_full, fifo_empty, pop;
  logic [CntW-1:0] count;
  logic            err_q;

`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
  logic [IdxW-1:0] rr_q, rr_d;

  // Round-robin: first requester at or after the pointer, wrapping.
  always_comb begin
    cand = '0;
    for (int k = NumInp - 1; k >= 0; k--) begin
      if (inp_req_i[(int'(rr_q) + k) % NumInp].req) begin
        cand = IdxW'((int'(rr_q) + k) % NumInp);
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    cand = '0;
    for (int k = NumInp - 1; k >= 0; k--) begin
      if (inp_req_i[k].req) begin
        cand = IdxW'(k);
      end
    end
  end
`endif

  always_comb begin
    any_req = 1'b0;
    for (int i = 0; i < NumInp; i++) begin
      any_req = any_req | inp_req_i[i].req;
    end
  end

  // While HOLD is active the latched index is forwarded regardless of other
  // requests, keeping the a-channel stable until gnt. A full FIFO blocks the
  // request outright, so no handshake can complete then.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push    = 1'b0;
    sel     = (state_q == HOLD) ? hold_q : cand;
    forward = 1'b0;
`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
    rr_d    = rr_q;
`endif

    if (state_q == HOLD) begin
      if (!inp_req_i[hold_q].req) begin
        state_d = IDLE;
      end else begin
        forward = ~fifo_full;
      end
    end else begin
      forward = any_req & ~fifo_full;
    end

    if (forward) begin
      if (mgr_rsp_i.gnt) begin
        push    = 1'b1;
        state_d = IDLE;
`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
        rr_d    = IdxW'((int'(sel) + 1) % NumInp);
`endif
      end else begin
        state_d = HOLD;
        hold_d  = sel;
      end
    end
  end

  // Request forwarding and response routing; rready defaults high with an
  // empty FIFO so stray responses are drained instead of stalling the bus.
  always_comb begin
    mgr_req_o        = '0;
    mgr_req_o.rready = fifo_empty ? 1'b1 : inp_req_i[head].rready;
    if (forward) begin
      mgr_req_o.req = 1'b1;
      mgr_req_o.a   = inp_req_i[sel].a;
    end
    for (int i = 0; i < NumInp; i++) begin
      inp_rsp_o[i]   = '0;
      inp_rsp_o[i].r = mgr_rsp_i.r;
    end
    if (forward) begin
      inp_rsp_o[sel].gnt = mgr_rsp_i.gnt;
    end
    if (!fifo_empty) begin
      inp_rsp_o[head].rvalid = mgr_rsp_i.rvalid;
    end
  end

  assign pop = mgr_rsp_i.rvalid & mgr_req_o.rready & ~fifo_empty;

  idma_obi_write_arb_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_idx_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_q | (mgr_rsp_i.rvalid & fifo_empty);
`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign busy_o = (count != '0) | any_req;
  assign err_o  = err_q;

endmodule

// File: tb/tb_idma_obi_write_arbiter.sv
// Directed bench for idma_obi_write_arbiter (4 engines, 4 outstanding).
module tb_idma_obi_write_arbiter;
  import idma_obi_arb_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] rready;
    logic       gnt;
    logic       rvalid;
    logic       e_req;
    int         e_idx;
    logic [3:0] e_gnt;
    logic [3:0] e_rvalid;
    logic       e_rready;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  logic     clk;
  logic     rst;
  obi_req_t inp_req [4];
  obi_rsp_t inp_rsp [4];
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp;
  logic     busy;
  logic     err;

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;
  vec_t vecs[$];

  idma_obi_write_arbiter #(
    .NumInp         (4),
    .MaxOutstanding (4),
    .write_req_t    (obi_req_t),
    .write_rsp_t    (obi_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .inp_req_i (inp_req),
    .inp_rsp_o (inp_rsp),
    .mgr_req_o (mgr_req),
    .mgr_rsp_i (mgr_rsp),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] ry, logic g, logic rv,
                              logic er, int ei, logic [3:0] eg, logic [3:0] erv,
                              logic ery, logic eb, logic ee);
    vec_t v;
    v.rst = r; v.req = rq; v.rready = ry; v.gnt = g; v.rvalid = rv;
    v.e_req = er; v.e_idx = ei; v.e_gnt = eg; v.e_rvalid = erv;
    v.e_rready = ery; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(int i);
    return 32'h1000 + 32'(i * 16);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL step %0d %s: got %0h expected %0h", step, name, act, exp_v);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    logic [3:0] g, rv;
    for (int i = 0; i < 4; i++) begin
      g[i]  = inp_rsp[i].gnt;
      rv[i] = inp_rsp[i].rvalid;
    end
    cmp("mgr_req", 32'(mgr_req.req), 32'(v.e_req));
    if (v.e_req) cmp("mgr_addr", mgr_req.a.addr, addr_of(v.e_idx));
    cmp("inp_gnt", 32'(g), 32'(v.e_gnt));
    cmp("inp_rvalid", 32'(rv), 32'(v.e_rvalid));
    cmp("mgr_rready", 32'(mgr_req.rready), 32'(v.e_rready));
    cmp("busy", 32'(busy), 32'(v.e_busy));
    cmp("err", 32'(err), 32'(v.e_err));
    cmp("r_bcast", inp_rsp[3].r.rdata, 32'hA5A5_0000 + 32'(step));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    for (int i = 0; i < 4; i++) begin
      inp_req[i].req     = v.rst ? 1'b0 : v.req[i];
      inp_req[i].rready  = v.rst ? 1'b1 : v.rready[i];
      inp_req[i].a.addr  = addr_of(i);
      inp_req[i].a.we    = 1'b1;
      inp_req[i].a.be    = 4'hF;
      inp_req[i].a.wdata = 32'(i);
      inp_req[i].a.aid   = '0;
    end
    mgr_rsp.gnt     = v.rst ? 1'b0 : v.gnt;
    mgr_rsp.rvalid  = v.rst ? 1'b0 : v.rvalid;
    mgr_rsp.r.rdata = 32'hA5A5_0000 + 32'(step);
    mgr_rsp.r.rid   = '0;
    mgr_rsp.r.err   = 1'b0;
    #1;
    if (!v.rst) checkOutput(v);
    @(posedge clk);
    #1;
    step++;
  endtask

  initial begin
    applyStimulus(mk(1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    applyStimulus(mk(1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`ifndef IDMA_OBI_WRITE_ARB_PRIO_EN
    // reset state, then single requester with immediate gnt
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 4'h2, 4'hF, 1, 0, 1, 1, 4'h2, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h2, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    // all four requesting, round-robin 0,1,2,3,0 with responses one behind
    vecs.push_back(mk(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 1, 1, 1, 4'h2, 4'h1, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 1, 1, 2, 4'h4, 4'h2, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 1, 1, 3, 4'h8, 4'h4, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 1, 1, 0, 4'h1, 4'h8, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    // grant stall on inp2 while inp0 joins; inp2 stays locked
    vecs.push_back(mk(0, 4'h4, 4'hF, 0, 0, 1, 2, 4'h0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h5, 4'hF, 0, 0, 1, 2, 4'h0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h5, 4'hF, 0, 0, 1, 2, 4'h0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h5, 4'hF, 1, 0, 1, 2, 4'h4, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h1, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h4, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    // fill to MaxOutstanding, blocked, one pop, grant resumes
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 1, 4'h2, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 2, 4'h4, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 3, 4'h8, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 1, 0, 0, 4'h0, 4'h2, 1, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 0, 1, 1, 4'h2, 4'h0, 1, 1, 0));
    // drain head inp2, then inp3 backpressures for two cycles
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h4, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'h7, 0, 1, 0, 0, 4'h0, 4'h8, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'h7, 0, 1, 0, 0, 4'h0, 4'h8, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h8, 1, 1, 0));
    // reset with two outstanding, stray rvalid sets sticky err
    vecs.push_back(mk(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n]);
    end

    // held request dropped before gnt: released without a FIFO entry
    applyStimulus(mk(0, 4'h2, 4'hF, 0, 0, 1, 1, 4'h0, 4'h0, 1, 1, 0));
    applyStimulus(mk(0, 4'h4, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0));
    applyStimulus(mk(0, 4'h4, 4'hF, 1, 0, 1, 2, 4'h4, 4'h0, 1, 1, 0));
    applyStimulus(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h4, 1, 1, 0));
    applyStimulus(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
`else
    // fixed priority: inp0 beats inp2 on every arbitration
    applyStimulus(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
    applyStimulus(mk(0, 4'h5, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 1, 1, 0));
    applyStimulus(mk(0, 4'h5, 4'hF, 1, 1, 1, 0, 4'h1, 4'h1, 1, 1, 0));
    applyStimulus(mk(0, 4'h4, 4'hF, 1, 1, 1, 2, 4'h4, 4'h1, 1, 1, 0));
    applyStimulus(mk(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'h4, 1, 1, 0));
    applyStimulus(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
